// File: rtl/rotate_scan_ctrl.sv
// Frame sequencer for rotate_matrix: raster-scans the destination pixels,
// registers the rotated source coordinate and emits it on a valid/ready stream.
module rotate_scan_ctrl #(
   parameter int unsigned DIM_WIDTH   = 11,
   parameter int unsigned ANGLE_WIDTH = 10,
   parameter int unsigned FRAC_BITS   = 0
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             start,
   input  logic                             abort,
   input  logic [ANGLE_WIDTH-1:0]           cos_theta,
   input  logic [ANGLE_WIDTH-1:0]           sin_theta,
   input  logic [DIM_WIDTH-1:0]             num_cols,
   input  logic [DIM_WIDTH-1:0]             num_rows,
   output logic                             busy,
   output logic                             done,
   output logic [ANGLE_WIDTH-1:0]           rot_cos,
   output logic [ANGLE_WIDTH-1:0]           rot_sin,
   output logic [DIM_WIDTH-1:0]             rot_num_cols,
   output logic [DIM_WIDTH-1:0]             rot_num_rows,
   output logic [DIM_WIDTH:0]               rot_xi,
   output logic [DIM_WIDTH:0]               rot_yi,
   input  logic [DIM_WIDTH+FRAC_BITS:0]     rot_xo,
   input  logic [DIM_WIDTH+FRAC_BITS:0]     rot_yo,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [DIM_WIDTH-1:0]             out_dst_x,
   output logic [DIM_WIDTH-1:0]             out_dst_y,
   output logic [DIM_WIDTH+FRAC_BITS:0]     out_src_x,
   output logic [DIM_WIDTH+FRAC_BITS:0]     out_src_y,
   output logic                             out_in_bounds,
   output logic                             out_sof,
   output logic                             out_eol,
   output logic                             out_eof
);

   localparam int unsigned OUT_WIDTH = DIM_WIDTH + 1 + FRAC_BITS;
   localparam int unsigned CMP_WIDTH = OUT_WIDTH + 1;

   typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, LAST = 2'd2} state_t;

   state_t                 state, state_nxt;
   logic [DIM_WIDTH-1:0]   x_cnt, y_cnt, x_cnt_nxt, y_cnt_nxt;
   logic                   busy_nxt, done_nxt, valid_nxt;
   logic [ANGLE_WIDTH-1:0] cos_nxt, sin_nxt;
   logic [DIM_WIDTH-1:0]   cols_nxt, rows_nxt;
   logic [DIM_WIDTH-1:0]   dst_x_nxt, dst_y_nxt;
   logic [OUT_WIDTH-1:0]   src_x_nxt, src_y_nxt;
   logic                   in_bounds_nxt, sof_nxt, eol_nxt, eof_nxt;

   logic signed [OUT_WIDTH-1:0] int_x, int_y;
   logic signed [CMP_WIDTH-1:0] int_x_ext, int_y_ext, cols_ext, rows_ext;
   logic                        in_bounds_c, last_col_c, last_row_c, advance_c;

   // Destination coordinate into the rotator; MSB is a zero sign bit.
   assign rot_xi = {1'b0, x_cnt};
   assign rot_yi = {1'b0, y_cnt};

   // Integer part of the rotated source compared against the latched image size.
   assign int_x       = $signed(rot_xo) >>> FRAC_BITS;
   assign int_y       = $signed(rot_yo) >>> FRAC_BITS;
   assign int_x_ext   = {int_x[OUT_WIDTH-1], int_x};
   assign int_y_ext   = {int_y[OUT_WIDTH-1], int_y};
   assign cols_ext    = {{(CMP_WIDTH-DIM_WIDTH){1'b0}}, rot_num_cols};
   assign rows_ext    = {{(CMP_WIDTH-DIM_WIDTH){1'b0}}, rot_num_rows};
   assign in_bounds_c = !int_x_ext[CMP_WIDTH-1] && (int_x_ext < cols_ext) &&
                        !int_y_ext[CMP_WIDTH-1] && (int_y_ext < rows_ext);

   assign last_col_c = (x_cnt == rot_num_cols - DIM_WIDTH'(1));
   assign last_row_c = (y_cnt == rot_num_rows - DIM_WIDTH'(1));
   assign advance_c  = (state == SCAN) && (!out_valid || out_ready);

   // Next-state and next-output logic; every register holds by default.
   always_comb begin
      state_nxt     = state;
      busy_nxt      = busy;
      done_nxt      = 1'b0;
      valid_nxt     = out_valid;
      x_cnt_nxt     = x_cnt;
      y_cnt_nxt     = y_cnt;
      cos_nxt       = rot_cos;
      sin_nxt       = rot_sin;
      cols_nxt      = rot_num_cols;
      rows_nxt      = rot_num_rows;
      dst_x_nxt     = out_dst_x;
      dst_y_nxt     = out_dst_y;
      src_x_nxt     = out_src_x;
      src_y_nxt     = out_src_y;
      in_bounds_nxt = out_in_bounds;
      sof_nxt       = out_sof;
      eol_nxt       = out_eol;
      eof_nxt       = out_eof;

      if (abort) begin
         state_nxt = IDLE;
         busy_nxt  = 1'b0;
         valid_nxt = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  cos_nxt   = cos_theta;
                  sin_nxt   = sin_theta;
                  cols_nxt  = num_cols;
                  rows_nxt  = num_rows;
                  x_cnt_nxt = '0;
                  y_cnt_nxt = '0;
                  // An empty image finishes at once without emitting beats.
                  if (num_cols == '0 || num_rows == '0) begin
                     done_nxt = 1'b1;
                  end else begin
                     busy_nxt  = 1'b1;
                     state_nxt = SCAN;
                  end
               end
            end
            SCAN: begin
               if (advance_c) begin
                  valid_nxt     = 1'b1;
                  dst_x_nxt     = x_cnt;
                  dst_y_nxt     = y_cnt;
                  src_x_nxt     = rot_xo;
                  src_y_nxt     = rot_yo;
                  in_bounds_nxt = in_bounds_c;
                  sof_nxt       = (x_cnt == '0) && (y_cnt == '0);
                  eol_nxt       = last_col_c;
                  eof_nxt       = last_col_c && last_row_c;
                  if (last_col_c && last_row_c) begin
                     state_nxt = LAST;
                  end else if (last_col_c) begin
                     x_cnt_nxt = '0;
                     y_cnt_nxt = y_cnt + DIM_WIDTH'(1);
                  end else begin
                     x_cnt_nxt = x_cnt + DIM_WIDTH'(1);
                  end
               end
            end
            LAST: begin
               if (out_valid && out_ready) begin
                  valid_nxt = 1'b0;
                  done_nxt  = 1'b1;
                  busy_nxt  = 1'b0;
                  state_nxt = IDLE;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         busy          <= 1'b0;
         done          <= 1'b0;
         out_valid     <= 1'b0;
         x_cnt         <= '0;
         y_cnt         <= '0;
         rot_cos       <= '0;
         rot_sin       <= '0;
         rot_num_cols  <= '0;
         rot_num_rows  <= '0;
         out_dst_x     <= '0;
         out_dst_y     <= '0;
         out_src_x     <= '0;
         out_src_y     <= '0;
         out_in_bounds <= 1'b0;
         out_sof       <= 1'b0;
         out_eol       <= 1'b0;
         out_eof       <= 1'b0;
      end else begin
         state         <= state_nxt;
         busy          <= busy_nxt;
         done          <= done_nxt;
         out_valid     <= valid_nxt;
         x_cnt         <= x_cnt_nxt;
         y_cnt         <= y_cnt_nxt;
         rot_cos       <= cos_nxt;
         rot_sin       <= sin_nxt;
         rot_num_cols  <= cols_nxt;
         rot_num_rows  <= rows_nxt;
         out_dst_x     <= dst_x_nxt;
         out_dst_y     <= dst_y_nxt;
         out_src_x     <= src_x_nxt;
         out_src_y     <= src_y_nxt;
         out_in_bounds <= in_bounds_nxt;
         out_sof       <= sof_nxt;
         out_eol       <= eol_nxt;
         out_eof       <= eof_nxt;
      end
   end

endmodule

// File: tb/tb_rotate_scan_ctrl.sv
// Directed bench for rotate_scan_ctrl with a behavioural centre-rotation stand-in.
module tb_rotate_scan_ctrl;

   localparam int unsigned DW = 11;
   localparam int unsigned AW = 10;
   localparam int unsigned OW = 12;

   logic          clk = 1'b0;
   logic          reset, start, abort, out_ready;
   logic [AW-1:0] cos_theta, sin_theta;
   logic [DW-1:0] num_cols, num_rows;
   logic          busy, done, out_valid;
   logic [AW-1:0] rot_cos, rot_sin;
   logic [DW-1:0] rot_num_cols, rot_num_rows;
   logic [DW:0]   rot_xi, rot_yi;
   logic [OW-1:0] rot_xo, rot_yo;
   logic [DW-1:0] out_dst_x, out_dst_y;
   logic [OW-1:0] out_src_x, out_src_y;
   logic          out_in_bounds, out_sof, out_eol, out_eof;

   int total = 0;
   int bad   = 0;

   rotate_scan_ctrl #(.DIM_WIDTH(DW), .ANGLE_WIDTH(AW), .FRAC_BITS(0)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .cos_theta(cos_theta), .sin_theta(sin_theta),
      .num_cols(num_cols), .num_rows(num_rows),
      .busy(busy), .done(done),
      .rot_cos(rot_cos), .rot_sin(rot_sin),
      .rot_num_cols(rot_num_cols), .rot_num_rows(rot_num_rows),
      .rot_xi(rot_xi), .rot_yi(rot_yi), .rot_xo(rot_xo), .rot_yo(rot_yo),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_dst_x(out_dst_x), .out_dst_y(out_dst_y),
      .out_src_x(out_src_x), .out_src_y(out_src_y),
      .out_in_bounds(out_in_bounds), .out_sof(out_sof),
      .out_eol(out_eol), .out_eof(out_eof)
   );

   always #5 clk = ~clk;

   // Rotation about the image centre, 1.0 = 256.
   int cs, sn, cx, cy, dx, dy;
   always_comb begin
      cs     = int'($signed(rot_cos));
      sn     = int'($signed(rot_sin));
      cx     = int'(rot_num_cols) / 2;
      cy     = int'(rot_num_rows) / 2;
      dx     = int'(rot_xi) - cx;
      dy     = int'(rot_yi) - cy;
      rot_xo = OW'(((cs * dx - sn * dy) >>> 8) + cx);
      rot_yo = OW'(((sn * dx + cs * dy) >>> 8) + cy);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] beat_vec();
      return 64'({out_dst_x, out_dst_y, out_src_x, out_src_y,
                  out_in_bounds, out_sof, out_eol, out_eof});
   endfunction

   // Expected beat for index i: identity when c>0, 180 degrees otherwise.
   function automatic logic [63:0] exp_vec(input int c, input int nc, input int nr, input int i);
      int  x, y, sx, sy;
      logic ib;
      x  = i % nc;
      y  = i / nc;
      sx = (c > 0) ? x : nc - x;
      sy = (c > 0) ? y : nr - y;
      ib = (sx >= 0) && (sx < nc) && (sy >= 0) && (sy < nr);
      return 64'({DW'(x), DW'(y), OW'(sx), OW'(sy), ib,
                  (i == 0), (x == nc - 1), (i == nc * nr - 1)});
   endfunction

   // Runs one frame; cut_after>=0 aborts (or resets) once that many beats are accepted.
   task automatic run_frame(input int c, input int nc, input int nr, input bit stall,
                            input bit midstart, input int cut_after, input bit cut_rst);
      int          beats, last_k;
      bit          holding, seen_done, ms_done;
      logic [63:0] hold_val;
      beats = 0; last_k = 0; holding = 0; seen_done = 0; ms_done = 0; hold_val = '0;
      cos_theta = AW'(c);
      sin_theta = '0;
      num_cols  = DW'(nc);
      num_rows  = DW'(nr);
      start     = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("busy_on_start", 64'(busy), 64'(1));
      for (int k = 0; k < 400; k++) begin
         start     = 1'b0;
         out_ready = stall ? (k % 3 == 0) : 1'b1;
         if (holding) check("hold_stable", {beat_vec()[62:0], out_valid}, {hold_val[62:0], 1'b1});
         if (done) begin
            seen_done = 1;
            check("beat_count", 64'(beats), 64'(nc * nr));
            check("done_latency", 64'(k), 64'(last_k + 1));
            check("done_busy", 64'(busy), 64'(0));
            break;
         end
         if (!stall && out_valid && beats == 0) check("first_latency", 64'(k), 64'(1));
         holding = 0;
         if (out_valid && out_ready) begin
            if (!stall) check("beat_gap", 64'(k), 64'(beats + 1));
            check($sformatf("beat%0d", beats), beat_vec(), exp_vec(c, nc, nr, beats));
            beats++;
            last_k = k;
         end else if (out_valid) begin
            holding  = 1;
            hold_val = beat_vec();
         end
         if (midstart && !ms_done && beats == 5) begin
            start     = 1'b1;
            cos_theta = '0;
            ms_done   = 1;
         end
         if (cut_after >= 0 && beats == cut_after) begin
            if (cut_rst) reset = 1'b1;
            else         abort = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            abort = 1'b0;
            check("cut_valid", 64'(out_valid), 64'(0));
            check("cut_busy", 64'(busy), 64'(0));
            check("cut_done", 64'(done), 64'(0));
            if (cut_rst) begin
               check("rst_shadow", 64'({rot_cos, rot_num_cols, rot_xi}), 64'(0));
               check("rst_outs", {beat_vec()[62:0], out_valid}, 64'(0));
            end
            repeat (2) begin
               @(posedge clk); #1;
               check("cut_no_done", 64'(done), 64'(0));
            end
            return;
         end
         @(posedge clk); #1;
      end
      if (!seen_done) check("frame_timeout", 64'(0), 64'(1));
      @(posedge clk); #1;
      check("done_pulse", 64'({done, busy, out_valid}), 64'(0));
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
      cos_theta = '0; sin_theta = '0; num_cols = '0; num_rows = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_ctl", 64'({busy, done, out_valid}), 64'(0));
      check("reset_outs", beat_vec(), 64'(0));
      check("reset_rot", 64'({rot_cos, rot_sin, rot_num_cols, rot_num_rows, rot_xi, rot_yi}), 64'(0));
      reset = 1'b0;
      @(posedge clk); #1;

      run_frame(256, 8, 4, 1'b0, 1'b0, -1, 1'b0);
      run_frame(-256, 8, 4, 1'b0, 1'b0, -1, 1'b0);
      run_frame(256, 4, 2, 1'b1, 1'b0, -1, 1'b0);
      run_frame(256, 8, 4, 1'b0, 1'b1, -1, 1'b0);
      run_frame(256, 1, 1, 1'b0, 1'b0, -1, 1'b0);

      // Empty image: done on the next cycle, no beats, never busy.
      cos_theta = 10'd256; num_cols = '0; num_rows = 11'd4; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("zero_done", 64'({done, busy, out_valid}), 64'(3'b100));
      @(posedge clk); #1;
      check("zero_after", 64'({done, busy, out_valid}), 64'(0));

      run_frame(256, 8, 4, 1'b0, 1'b0, 5, 1'b0);
      run_frame(256, 8, 4, 1'b0, 1'b0, -1, 1'b0);
      run_frame(256, 8, 4, 1'b1, 1'b0, 10, 1'b1);
      run_frame(-256, 4, 2, 1'b0, 1'b0, -1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
